// File: rtl/four_bank_mem_pkg.sv
// rtl/four_bank_mem_pkg.sv - shared timing constants, address field positions and bank index type
package four_bank_mem_pkg;

  localparam int BANK_CYCLES = 4;
  localparam int RD_LAT      = 2;
  localparam int BANK_W      = 2;
  localparam int NUM_BANKS   = 1 << BANK_W;
  localparam int BANK_LSB    = 1;
  localparam int ROW_LSB     = BANK_LSB + BANK_W;
  localparam int CNT_W       = $clog2(BANK_CYCLES + 1);

  typedef logic [BANK_W-1:0] bank_idx_t;

endpackage

// File: rtl/mem_bank.sv
// rtl/mem_bank.sv - one interleaved bank: row storage, busy down-counter, accept-qualified strobes
module mem_bank
  import four_bank_mem_pkg::*;
#(
  parameter int ROW_W  = 13,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              rd,
  input  logic              wr,
  input  logic [ROW_W-1:0]  row,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              rd_stb,
  output logic [DATA_W-1:0] rd_word
);

  logic [DATA_W-1:0] mem [2**ROW_W];
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              accept;
  logic              wr_stb;

  // sel already excludes illegal requests; busy gates same-bank back-to-back access
  assign accept = sel & (rd ^ wr) & ~busy;
  assign rd_stb = accept & rd;
  assign wr_stb = accept & wr;

  always_comb begin
    cnt_nxt = cnt;
    if (accept) begin
      cnt_nxt = CNT_W'(BANK_CYCLES);
    end else if (cnt != '0) begin
      cnt_nxt = cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      busy <= (cnt_nxt != '0);
    end
  end

  // storage survives rst so committed writes are kept
  always_ff @(posedge clk) begin
    if (wr_stb) begin
      mem[row] <= data_in;
    end
  end

  assign rd_word = mem[row];

endmodule

// File: rtl/four_bank_mem.sv
// rtl/four_bank_mem.sv - four-bank word-interleaved memory; FOUR_BANK_MEM_ALIGN_CHECK_EN rejects odd addresses
module four_bank_mem
  import four_bank_mem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_W-1:0]    data_in,
  input  logic                 wr,
  input  logic                 rd,
  output logic [DATA_W-1:0]    data_out,
  output logic                 valid_out,
  output logic                 stall,
  output logic [NUM_BANKS-1:0] busy,
  output logic                 err
);

  localparam int ROW_W = ADDR_W - ROW_LSB;

`ifdef FOUR_BANK_MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  bank_idx_t         bank;
  logic [ROW_W-1:0]  row;
  logic              req;
  logic              illegal;
  logic              legal_req;
  logic              rd_acc;
  logic [DATA_W-1:0] sel_word;

  logic [NUM_BANKS-1:0] rd_stb;
  logic [DATA_W-1:0]    rd_word [NUM_BANKS];

  logic [RD_LAT-1:0] vld_pipe;
  logic [DATA_W-1:0] dat_pipe [RD_LAT];

  assign bank = addr[ROW_LSB-1:BANK_LSB];
  assign row  = addr[ADDR_W-1:ROW_LSB];
  assign req  = rd | wr;

  // illegal requests neither stall nor accept; they only flag err next cycle
  assign illegal   = (rd & wr) | (ALIGN_CHECK & req & addr[0]);
  assign legal_req = ~illegal;
  assign stall     = req & legal_req & busy[bank];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= illegal;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    mem_bank #(
      .ROW_W  (ROW_W),
      .DATA_W (DATA_W)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .sel     (legal_req & (bank == bank_idx_t'(b))),
      .rd      (rd),
      .wr      (wr),
      .row     (row),
      .data_in (data_in),
      .busy    (busy[b]),
      .rd_stb  (rd_stb[b]),
      .rd_word (rd_word[b])
    );
  end

  assign rd_acc   = |rd_stb;
  assign sel_word = rd_word[bank];

  // zero-filled when no read is in a stage, so data_out is 0 whenever valid_out is 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        dat_pipe[i] <= '0;
      end
    end else begin
      vld_pipe[0] <= rd_acc;
      dat_pipe[0] <= rd_acc ? sel_word : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign valid_out = vld_pipe[RD_LAT-1];
  assign data_out  = dat_pipe[RD_LAT-1];

endmodule

// File: tb/tb_four_bank_mem.sv
// tb/tb_four_bank_mem.sv - randomized and directed bench for four_bank_mem against a cycle-count model
module tb_four_bank_mem;

  localparam int BANK_CYC = 4;
  localparam int LAT      = 2;

`ifdef FOUR_BANK_MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr = '0;
  logic [15:0] data_in = '0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [15:0] data_out;
  logic        valid_out;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  four_bank_mem #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .data_in   (data_in),
    .wr        (wr),
    .rd        (rd),
    .data_out  (data_out),
    .valid_out (valid_out),
    .stall     (stall),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // model: bank b busy in cycle c iff c <= busy_until[b]; reads queued with the cycle they appear
  typedef struct {
    int          due;
    logic [15:0] d;
  } rd_t;

  int          busy_until [4];
  logic [15:0] mdl_mem [0:32767];
  rd_t         rq [$];
  logic        err_nxt;

  always @(negedge clk) begin : cmp
    logic [3:0]  eb;
    logic        ev;
    logic [15:0] ed;
    logic        ill;
    logic        es;
    int          bk;
    if (cyc > 0) begin
      if (rst) begin
        chk("rst_busy", {28'd0, busy}, 0);
        chk("rst_valid", {31'd0, valid_out}, 0);
        chk("rst_data", {16'd0, data_out}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_stall", {31'd0, stall}, 0);
        for (int b = 0; b < 4; b++) busy_until[b] = -1;
        rq.delete();
        err_nxt = 1'b0;
      end else begin
        for (int b = 0; b < 4; b++) eb[b] = (cyc <= busy_until[b]);
        bk  = int'(addr[2:1]);
        ill = (rd & wr) | (ALIGN & (rd | wr) & addr[0]);
        es  = (rd | wr) & !ill & eb[bk];
        ev  = 1'b0;
        ed  = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
          ev = 1'b1;
          ed = rq[0].d;
          void'(rq.pop_front());
        end
        chk("m_busy", {28'd0, busy}, {28'd0, eb});
        chk("m_stall", {31'd0, stall}, {31'd0, es});
        chk("m_err", {31'd0, err}, {31'd0, err_nxt});
        chk("m_valid", {31'd0, valid_out}, {31'd0, ev});
        chk("m_data", {16'd0, data_out}, {16'd0, ed});
        err_nxt = ill;
        if ((rd ^ wr) && !ill && !eb[bk]) begin
          busy_until[bk] = cyc + BANK_CYC;
          if (wr) mdl_mem[addr[15:1]] = data_in;
          else rq.push_back('{due: cyc + LAT, d: mdl_mem[addr[15:1]]});
        end
      end
    end
  end

  task automatic idle();
    @(posedge clk);
    #1;
    rd = 1'b0;
    wr = 1'b0;
    @(negedge clk);
  endtask

  // holds the request while stalled; ns returns how many cycles it stalled
  task automatic issue(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                       output int ns);
    @(posedge clk);
    #1;
    rd = r;
    wr = w;
    addr = a;
    data_in = d;
    @(negedge clk);
    ns = 0;
    while (stall && ns < 40) begin
      @(negedge clk);
      ns++;
    end
    if (ns >= 40) chk("issue_timeout", ns, 0);
  endtask

  initial begin
    int ns;
    for (int i = 0; i < 32768; i++) mdl_mem[i] = '0;
    for (int b = 0; b < 4; b++) busy_until[b] = -1;
    err_nxt = 1'b0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", {28'd0, busy}, 32'h0);
    chk("reset_valid", {31'd0, valid_out}, 32'h0);
    chk("reset_data", {16'd0, data_out}, 32'h0);
    chk("reset_err", {31'd0, err}, 32'h0);

    // single write then read of bank 0
    issue(1'b0, 1'b1, 16'h0010, 16'h1234, ns);
    chk("wr0_stall", ns, 0);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("wr0_busy", {28'd0, busy}, 32'h1);
    end
    issue(1'b1, 1'b0, 16'h0010, 16'h0000, ns);
    chk("rd0_stall", ns, 0);
    chk("rd0_busy_free", {28'd0, busy}, 32'h0);
    idle();
    chk("rd0_not_yet", {31'd0, valid_out}, 32'h0);
    idle();
    chk("rd0_valid", {31'd0, valid_out}, 32'h1);
    chk("rd0_data", {16'd0, data_out}, 32'h1234);

    // line fill across all four banks, then streamed reads
    repeat (5) idle();
    for (int i = 0; i < 4; i++) issue(1'b0, 1'b1, 16'h0040 + 16'(2 * i), 16'h00A0 + 16'(i), ns);
    repeat (5) idle();
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 1'b0, 16'h0040 + 16'(2 * i), 16'h0000, ns);
      chk("fill_rd_stall", ns, 0);
      if (i >= 2) begin
        chk("fill_valid", {31'd0, valid_out}, 32'h1);
        chk("fill_data", {16'd0, data_out}, 32'h00A0 + 32'(i - 2));
      end
    end
    idle();
    chk("fill_data2", {16'd0, data_out}, 32'h00A2);
    chk("fill_busy_all", {28'd0, busy}, 32'hF);
    idle();
    chk("fill_data3", {16'd0, data_out}, 32'h00A3);

    // same-bank conflict: read waits out the write's busy window
    repeat (5) idle();
    issue(1'b0, 1'b1, 16'h0024, 16'h5A5A, ns);
    issue(1'b1, 1'b0, 16'h0024, 16'h0000, ns);
    chk("conflict_stalls", ns, 4);
    chk("conflict_no_valid", {31'd0, valid_out}, 32'h0);
    idle();
    idle();
    chk("conflict_valid", {31'd0, valid_out}, 32'h1);
    chk("conflict_data", {16'd0, data_out}, 32'h5A5A);

    // rd & wr together
    repeat (5) idle();
    issue(1'b1, 1'b1, 16'h0008, 16'h7777, ns);
    chk("both_stall", {31'd0, stall}, 32'h0);
    idle();
    chk("both_err", {31'd0, err}, 32'h1);
    chk("both_busy", {28'd0, busy}, 32'h0);
    idle();
    chk("both_err_clear", {31'd0, err}, 32'h0);

    // odd address
    issue(1'b1, 1'b0, 16'h0011, 16'h0000, ns);
    idle();
    chk("odd_err", {31'd0, err}, ALIGN ? 32'h1 : 32'h0);
    idle();
    chk("odd_valid", {31'd0, valid_out}, ALIGN ? 32'h0 : 32'h1);
    chk("odd_data", {16'd0, data_out}, ALIGN ? 32'h0 : 32'h1234);

    // reset with a read in flight
    repeat (3) idle();
    issue(1'b1, 1'b0, 16'h0040, 16'h0000, ns);
    @(posedge clk);
    #1;
    rd = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", {31'd0, valid_out}, 32'h0);
    chk("midrst_busy", {28'd0, busy}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_dropped", {31'd0, valid_out}, 32'h0);

    // preload a small window so every random read has known contents
    for (int i = 0; i < 64; i++) issue(1'b0, 1'b1, 16'(2 * i), 16'($urandom), ns);
    idle();

    for (int k = 0; k < 3000; k++) begin
      int sel;
      @(posedge clk);
      #1;
      sel = int'($urandom_range(0, 99));
      rd = (sel < 40) || (sel >= 95);
      wr = (sel >= 40 && sel < 75) || (sel >= 95);
      addr = 16'($urandom_range(0, 127));
      data_in = 16'($urandom);
    end
    repeat (8) idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
